// File: rtl/lcd_cfah_ctrl.sv
// rtl/lcd_cfah_ctrl.sv - CFAH/HD44780 character LCD bus master with busy-flag polling
//
// Purpose: runs one request at a time (command write, data write, or read) on the
// 8-bit parallel LCD bus. Each bus cycle has three phases: setup, an enable pulse,
// and hold. When polling is enabled, a write is followed by status reads until
// busy-flag bit 7 clears or the poll budget runs out.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   i_start             request strobe; taken only while o_busy=0
//   i_rs, i_rw, i_wdata register select, direction (1=read), write data
//   o_rdata             read data, updated when a read completes
//   o_done, o_status    one-cycle completion pulse, 1 = busy-flag timeout
//   o_busy              transfer in progress
//   o_lcd_rs/rw/en      LCD control lines
//   io_lcd_data         LCD data bus, driven only during write phases
module lcd_cfah_ctrl #(
    parameter int G_T_SETUP    = 2,
    parameter int G_T_EN       = 12,
    parameter int G_T_HOLD     = 2,
    parameter int G_POLL_BF    = 1,
    parameter int G_BF_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_rs,
    input  logic       i_rw,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata,
    output logic       o_done,
    output logic       o_status,
    output logic       o_busy,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_en,
    inout  wire  [7:0] io_lcd_data
);

    localparam int T_MAX0 = (G_T_SETUP > G_T_HOLD) ? G_T_SETUP : G_T_HOLD;
    localparam int T_MAX  = (G_T_EN > T_MAX0) ? G_T_EN : T_MAX0;
    localparam int CNT_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int POLL_W = $clog2(G_BF_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  LD_SETUP = CNT_W'(G_T_SETUP - 1);
    localparam logic [CNT_W-1:0]  LD_EN    = CNT_W'(G_T_EN - 1);
    localparam logic [CNT_W-1:0]  LD_HOLD  = CNT_W'(G_T_HOLD - 1);
    localparam logic [POLL_W-1:0] POLL_MAX = POLL_W'(G_BF_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EN_HI,
        S_HOLD,
        S_BF_SETUP,
        S_BF_EN_HI,
        S_BF_HOLD,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [POLL_W-1:0]  poll_q, poll_d;
    logic               rs_q, rs_d;
    logic               rw_q, rw_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               status_q, status_d;
    logic               bf_q, bf_d;
    logic               last;
    logic               main_phase;
    logic [POLL_W-1:0]  poll_inc;

    assign last     = (cnt_q == '0);
    assign poll_inc = poll_q + POLL_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        poll_d   = poll_q;
        rs_d     = rs_q;
        rw_d     = rw_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        bf_d     = bf_q;

        // Phase counter runs down by default; transitions below reload it.
        if (!last) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    rs_d     = i_rs;
                    rw_d     = i_rw;
                    wdata_d  = i_wdata;
                    poll_d   = '0;
                    status_d = 1'b0;
                    cnt_d    = LD_SETUP;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (last) begin
                    cnt_d   = LD_EN;
                    state_d = S_EN_HI;
                end
            end
            S_EN_HI: begin
                if (last) begin
                    // Sample while en is still high, before the LCD releases the bus.
                    if (rw_q) begin
                        rdata_d = io_lcd_data;
                    end
                    cnt_d   = LD_HOLD;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (last) begin
                    if (!rw_q && (G_POLL_BF != 0)) begin
                        cnt_d   = LD_SETUP;
                        state_d = S_BF_SETUP;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_BF_SETUP: begin
                if (last) begin
                    cnt_d   = LD_EN;
                    state_d = S_BF_EN_HI;
                end
            end
            S_BF_EN_HI: begin
                if (last) begin
                    bf_d    = io_lcd_data[7];
                    cnt_d   = LD_HOLD;
                    state_d = S_BF_HOLD;
                end
            end
            S_BF_HOLD: begin
                if (last) begin
                    poll_d = poll_inc;
                    if (!bf_q) begin
                        status_d = 1'b0;
                        state_d  = S_DONE;
                    end else if (poll_inc == POLL_MAX) begin
                        status_d = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d   = LD_SETUP;
                        state_d = S_BF_SETUP;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            poll_q   <= '0;
            rs_q     <= 1'b0;
            rw_q     <= 1'b1;
            wdata_q  <= 8'h00;
            rdata_q  <= 8'h00;
            status_q <= 1'b0;
            bf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            poll_q   <= poll_d;
            rs_q     <= rs_d;
            rw_q     <= rw_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
            bf_q     <= bf_d;
        end
    end

    // Outside the requested transfer, the lines sit in status-read posture
    // (rs=0, rw=1), so the bus is never driven while rw=1.
    assign main_phase = (state_q == S_SETUP) || (state_q == S_EN_HI) || (state_q == S_HOLD);

    assign o_lcd_rs    = main_phase & rs_q;
    assign o_lcd_rw    = main_phase ? rw_q : 1'b1;
    assign o_lcd_en    = (state_q == S_EN_HI) || (state_q == S_BF_EN_HI);
    assign io_lcd_data = (main_phase && !rw_q) ? wdata_q : 8'bz;

    assign o_rdata  = rdata_q;
    assign o_status = status_q;
    assign o_done   = (state_q == S_DONE);
    assign o_busy   = (state_q != S_IDLE);

endmodule

// File: doc/lcd_cfah_ctrl.md
Name: lcd_cfah_ctrl

Overview:
- Bus master for the CFAH (HD44780-compatible) character LCD. It is the initiator that drives the 8-bit parallel rs/rw/en/data interface the LCD_CFAH_emul responder models.
- Accepts single-transfer requests from the AXI4-Lite LCD register slave: write command, write data, or read.
- Generates setup, enable-pulse and hold timing on the bus.
- After every write, it polls the busy flag (bit 7 of a status read) until it clears or a timeout expires.

Parameters:
G_T_SETUP, 2, clk cycles that rs/rw/data are stable before en rises (min 1)
G_T_EN, 12, clk cycles en is held high (min 2)
G_T_HOLD, 2, clk cycles rs/rw/data are held after en falls (min 1)
G_POLL_BF, 1, 1: poll busy flag after each write; 0: no polling
G_BF_TIMEOUT, 4096, max status reads per poll before timeout (min 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
i_start  in  1  request strobe, accepted only when o_busy=0
i_rs  in  1  0: command/status register, 1: data register
i_rw  in  1  0: write, 1: read
i_wdata  in  8  write data
o_rdata  out  8  read data; for reads valid with o_done
o_done  out  1  one-cycle completion pulse
o_status  out  1  0: OK, 1: busy-flag timeout (valid with o_done)
o_busy  out  1  transfer in progress
o_lcd_rs  out  1  LCD register select
o_lcd_rw  out  1  LCD read/write
o_lcd_en  out  1  LCD enable
io_lcd_data  inout  8  LCD data bus; driven only during write phases, else 'Z'

Behaviour:
- Reset (rst=1 sampled at clk edge):
  - State goes to IDLE.
  - o_rdata=0x00, o_done=0, o_status=0, o_busy=0.
  - o_lcd_rs=0, o_lcd_rw=1, o_lcd_en=0, io_lcd_data='Z'.
  - Reset in any state aborts the transfer immediately, with no o_done.
- States: IDLE, SETUP, EN_HI, HOLD, BF_SETUP, BF_EN_HI, BF_HOLD, DONE.
- One down-counter, loaded on each state entry with (phase length - 1).
- A state transitions when its counter reaches 0.
- IDLE:
  - o_busy=0.
  - On i_start=1: latch i_rs, i_rw, i_wdata; drive o_lcd_rs=i_rs and o_lcd_rw=i_rw; go to SETUP; o_busy=1 from the next cycle.
- SETUP (G_T_SETUP cycles):
  - Write: drive io_lcd_data with the latched data.
  - Then go to EN_HI.
- EN_HI (G_T_EN cycles):
  - o_lcd_en=1.
  - Read: capture io_lcd_data into o_rdata in the last EN_HI cycle, before en falls.
  - Then go to HOLD.
- HOLD (G_T_HOLD cycles):
  - o_lcd_en=0; rs, rw and write data remain stable.
  - Then go to BF_SETUP if (write and G_POLL_BF=1), else to DONE.
- BF_SETUP / BF_EN_HI / BF_HOLD:
  - Status read: o_lcd_rs=0, o_lcd_rw=1, bus released. Phase timing is identical to SETUP / EN_HI / HOLD.
  - Busy-flag sample taken in the last BF_EN_HI cycle.
  - Poll counter increments on each BF_HOLD exit.
  - BF_HOLD exit goes to:
    - DONE with o_status=0 if the sampled bit7=0.
    - DONE with o_status=1 if the poll counter reaches G_BF_TIMEOUT.
    - BF_SETUP otherwise.
- DONE:
  - o_done=1 for exactly one cycle; o_lcd_rw returns to 1 and the bus is released.
  - Next state is IDLE; o_busy=0 from the following cycle.
- Bus direction rule: io_lcd_data is driven only when the latched rw=0 and the state is SETUP, EN_HI or HOLD. Never drive while o_lcd_rw=1.
- i_start while o_busy=1 is ignored; no queueing.
- i_start on the cycle after o_done (state IDLE) is accepted.
- Latency from the accept edge to the o_done cycle:
  - No polling: G_T_SETUP+G_T_EN+G_T_HOLD+1 cycles.
  - Each poll iteration adds G_T_SETUP+G_T_EN+G_T_HOLD cycles.
- Read requests are never followed by a poll. o_rdata holds its value until the next read completes.
- The poll counter width is clog2(G_BF_TIMEOUT+1); it clears on IDLE exit.

Test Plan:
1. Reset held 5 cycles, then released -> o_lcd_en=0, o_lcd_rw=1, io_lcd_data='Z', o_busy=0, o_done=0. No en pulse until i_start.
2. G_POLL_BF=0, write rs=0 data=0x38 -> emulator o_rdata_val pulses with rdata=0x38; en high exactly 12 cycles; o_done 17 cycles after accept; o_status=0.
3. G_POLL_BF=1, emulator BUSY_FLAG_DURATION=40, write rs=1 data=0x41 -> emulator logs 0x41; status reads repeat until bit7=0; o_done with o_status=0; no en pulse after o_done.
4. Read rs=1 with emulator SEL_LCD=1, WDATA_LCD=0xA5 -> o_rdata=0xA5 at o_done; io_lcd_data never driven by the DUT (no X on the bus).
5. G_BF_TIMEOUT=4, emulator busy never clears (BUSY_FLAG_DURATION=255) -> exactly 4 status reads after the write; o_status=1 with o_done.
6. rst asserted mid-EN_HI of a write -> next cycle o_lcd_en=0, bus 'Z', o_busy=0, no o_done. A new write of 0x01 then completes normally.
